maf_rr_scheduler: RTL and testbench
===================================

// Module: maf_rr_scheduler
// PURPOSE
//  Shares one 5-tap moving-sum datapath among NCH requester channels.
//  - Round-robin arbiter grants at most one channel sample per cycle.
//  - Each channel keeps its own WIN-deep sample history and running sum.
//  - The granted sample updates its channel's sum. The result is emitted with its channel id.
//  - Sits between per-channel sample producers and a single downstream consumer.
// PARAMETERS
//  NCH  4  number of requester channels (2..8)
//  DW   5  sample width, unsigned
//  WIN  5  window length in samples
//  SW   8  sum width; must satisfy SW >= DW + clog2(WIN)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  reset      in   1       synchronous, active-high
//  req_valid  in   NCH     channel i has a sample on req_data[i*DW +: DW]
//  req_data   in   NCH*DW  packed per-channel samples
//  req_ready  out  NCH     one-hot (or zero) grant; a sample is accepted when req_valid[i] & req_ready[i]
//  chan_clr   in   NCH     clear history and sum of channel i
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_chan   out  clog2(NCH)  channel id of result
//  out_sum    out  SW      windowed sum after including the accepted sample
// BEHAVIOUR
//  Reset
//  - reset=1 clears all histories and sums to 0, sets the RR pointer to 0, and sets out_valid=0.
//  - out_chan and out_sum also reset to 0.
//  - req_ready is 0 while reset=1.
//  - A reset in the middle of operation drops any pending output; no result survives reset.
//  Stall
//  - stall = out_valid & ~out_ready.
//  - While stalled, req_ready=0 and out_* hold stable.
//  Arbitration (combinational req_ready)
//  - Eligible set: req_valid & ~chan_clr.
//  - The search starts at index ptr and wraps through NCH-1 back to 0.
//  - The first eligible channel gets its req_ready bit set.
//  - If nothing is eligible, or the block is stalled, req_ready=0.
//  - On accept of channel g: ptr <= (g+1) mod NCH. Otherwise ptr holds.
//  Datapath, on accept of channel g with sample d
//  - sum[g] <= sum[g] + d - hist[g][WIN-1], computed at full SW width.
//  - The shift to hist[g] puts d at [0]; the old [WIN-1] is discarded.
//  - The next cycle shows out_valid=1, out_chan=g, out_sum=new sum[g].
//  - Latency is exactly 1 cycle from the accept edge to out_valid.
//  - Back-to-back accepts give one result per cycle when out_ready=1.
//  - Output register update:
//    - If out_ready=1 (or out_valid=0) and nothing is accepted, out_valid <= 0.
//    - If out_ready=1 (or out_valid=0) and a sample is accepted, the register loads the new result.
//  Partial window
//  - History starts at zero, so the first k<WIN samples give the plain sum of those k samples.
//  - The maximum sum is WIN*(2^DW-1) = 155 at defaults. It fits SW, so there is no overflow or wrap.
//  chan_clr[i]
//  - Zeroes hist[i] and sum[i] on the same edge.
//  - It takes precedence: channel i is not granted that cycle, and its sample stays pending.
//  - A result already in the output register for channel i is not altered.
//  - Clearing other channels has no effect on channel i.
//  Other rules
//  - Un-granted channels' histories never change.
//  - A requester must hold req_valid and data until accepted.
// TESTING
//  1. Single channel
//     - Stimulus: ch0 sends 1,2,3,4,5,6,7, out_ready=1.
//     - Response: out_sum 1,3,6,10,15,20,25, out_chan=0, each 1 cycle after accept.
//  2. Fairness
//     - Stimulus: all 4 channels are held valid continuously.
//     - Response: grant order is 0,1,2,3,0,1,...; each channel gets exactly 1 grant per 4 cycles.
//  3. Saturation
//     - Stimulus: ch2 sends 31 repeatedly.
//     - Response: out_sum 31,62,93,124,155,155 with no wrap.
//  4. Backpressure
//     - Stimulus: out_ready=0 for 3 cycles while ch1,ch3 are valid.
//     - Response: req_ready=0 and out_* held; after release the grants resume in RR order.
//  5. Clear collision
//     - Stimulus: ch0 has history 5,5,5; in one cycle ch0 is valid with data 9 and chan_clr[0]=1.
//     - Response: no grant to ch0 that cycle; the next cycle ch0 is accepted with out_sum=9.
//  6. Reset mid-stream
//     - Stimulus: reset for 1 cycle while out_valid=1.
//     - Response: out_valid=0, all sums are 0, and the next ch0 sample of 4 gives out_sum=4.

Source files
------------

// File: rtl/maf_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : maf_rr_scheduler_if
//  Description : Bundle of request-side and result-side handshake signals
//                for the shared moving-sum scheduler.
//                  req_valid / req_data / req_ready : per-channel sample
//                                                     requests and grant
//                  chan_clr                         : per-channel clear
//                  out_valid / out_ready            : result handshake
//                  out_chan / out_sum               : result payload
//                master : sample producers plus downstream consumer
//                slave  : the scheduler
//                The parameters must match those of the scheduler that
//                the interface is connected to.
//  Revision    : 1.0  initial release
// ============================================================================
interface maf_rr_scheduler_if #(
   parameter int NCH = 4,
   parameter int DW  = 5,
   parameter int SW  = 8
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]    req_valid;
   logic [NCH*DW-1:0] req_data;
   logic [NCH-1:0]    req_ready;
   logic [NCH-1:0]    chan_clr;
   logic              out_valid;
   logic              out_ready;
   logic [CW-1:0]     out_chan;
   logic [SW-1:0]     out_sum;

   modport master (
      output req_valid,
      output req_data,
      output chan_clr,
      output out_ready,
      input  req_ready,
      input  out_valid,
      input  out_chan,
      input  out_sum
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  chan_clr,
      input  out_ready,
      output req_ready,
      output out_valid,
      output out_chan,
      output out_sum
   );
endinterface
`default_nettype wire

// File: rtl/maf_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : maf_rr_scheduler
//  Description : One WIN-tap moving-sum datapath shared by NCH channels.
//                A round-robin arbiter accepts at most one sample per cycle;
//                each channel keeps its own sample history and running sum,
//                and the updated sum is emitted one cycle after acceptance
//                together with the channel id.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous, active-high
//                bus    - maf_rr_scheduler_if.slave
//                           req_valid/req_data/req_ready  sample requests
//                           chan_clr                      per-channel clear
//                           out_valid/out_ready           result handshake
//                           out_chan/out_sum              result payload
//  Notes       : SW must be at least DW + clog2(WIN) so the full-window sum
//                never wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module maf_rr_scheduler #(
   parameter int NCH = 4,
   parameter int DW  = 5,
   parameter int WIN = 5,
   parameter int SW  = 8
) (
   input  wire logic           clk,
   input  wire logic           reset,
   maf_rr_scheduler_if.slave   bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DW-1:0] r_hist [NCH][WIN];
   logic [SW-1:0] r_sum  [NCH];
   logic [CW-1:0] r_ptr;
   logic          r_out_valid;
   logic [CW-1:0] r_out_chan;
   logic [SW-1:0] r_out_sum;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic [DW-1:0]  w_data [NCH];
   logic [NCH-1:0] w_elig;
   logic           w_stall;
   logic           w_found;
   logic [CW-1:0]  w_gidx;
   logic [NCH-1:0] w_grant;
   logic           w_accept;
   logic [SW-1:0]  w_new_sum;

   // (p + k) mod NCH for p < NCH and 0 <= k < NCH
   function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] p, input int k);
      int t;
      t = int'(p) + k;
      if (t >= NCH) t = t - NCH;
      return t[CW-1:0];
   endfunction

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_unpack
         assign w_data[i] = bus.req_data[i*DW +: DW];
      end
   endgenerate

   // A channel being cleared is held off so its sample lands in a fresh window.
   assign w_elig  = bus.req_valid & ~bus.chan_clr;
   assign w_stall = r_out_valid & ~bus.out_ready;

   // Round-robin search starting at r_ptr; the first eligible channel wins.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!w_found && w_elig[wrap_idx(r_ptr, k)]) begin
            w_found = 1'b1;
            w_gidx  = wrap_idx(r_ptr, k);
         end
      end
      // No grants during reset or while the result register is blocked.
      w_accept = w_found & ~w_stall & ~reset;
      w_grant  = '0;
      if (w_accept) w_grant[w_gidx] = 1'b1;
   end

   // Full-width add/subtract: the dropped sample is already part of the sum,
   // so the result never goes negative and never exceeds WIN*(2^DW-1).
   assign w_new_sum = r_sum[w_gidx] + SW'(w_data[w_gidx]) - SW'(r_hist[w_gidx][WIN-1]);

   // ------------------------------------------------------------------------
   // Per-channel history and running sum
   // ------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < NCH; i++) begin : g_chan
         always_ff @(posedge clk) begin
            if (reset || bus.chan_clr[i]) begin
               for (int k = 0; k < WIN; k++) r_hist[i][k] <= '0;
               r_sum[i] <= '0;
            end else if (w_grant[i]) begin
               for (int k = WIN-1; k > 0; k--) r_hist[i][k] <= r_hist[i][k-1];
               r_hist[i][0] <= w_data[i];
               r_sum[i]     <= w_new_sum;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Arbitration pointer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= wrap_idx(w_gidx, 1);
      end
   end

   // ------------------------------------------------------------------------
   // Result register: holds while stalled, otherwise follows this cycle's
   // accept. Payload is only reloaded on an accept.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_chan  <= '0;
         r_out_sum   <= '0;
      end else if (!w_stall) begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_out_chan <= w_gidx;
            r_out_sum  <= w_new_sum;
         end
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.out_valid = r_out_valid;
   assign bus.out_chan  = r_out_chan;
   assign bus.out_sum   = r_out_sum;

endmodule
`default_nettype wire

// File: tb/tb_maf_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maf_rr_scheduler
//  Description : Self-checking bench for maf_rr_scheduler (NCH=4, DW=5,
//                WIN=5, SW=8). Vector table followed by a hand-written
//                stall/latency sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maf_rr_scheduler;
   localparam int NCH = 4;
   localparam int DW  = 5;
   localparam int WIN = 5;
   localparam int SW  = 8;

   logic clk;
   logic reset;

   maf_rr_scheduler_if #(.NCH(NCH), .DW(DW), .SW(SW)) bus ();

   maf_rr_scheduler #(.NCH(NCH), .DW(DW), .WIN(WIN), .SW(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic [19:0] data;
      logic [3:0] clr;
      logic       ordy;
      logic [3:0] e_ready;
      logic       e_ov;
      logic [1:0] e_chan;
      logic [7:0] e_sum;
      logic       chk;
   } vec_t;

   vec_t vecs[$];
   int   n_checks;
   int   n_errors;

   task automatic add(input logic rst, input logic [3:0] valid,
                      input int d0, input int d1, input int d2, input int d3,
                      input logic [3:0] clr, input logic ordy,
                      input logic [3:0] e_ready, input logic e_ov,
                      input int e_chan, input int e_sum, input logic chk);
      vec_t v;
      v.rst     = rst;
      v.valid   = valid;
      v.data    = {d3[4:0], d2[4:0], d1[4:0], d0[4:0]};
      v.clr     = clr;
      v.ordy    = ordy;
      v.e_ready = e_ready;
      v.e_ov    = e_ov;
      v.e_chan  = e_chan[1:0];
      v.e_sum   = e_sum[7:0];
      v.chk     = chk;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int waited;
      n_checks = 0;
      n_errors = 0;

      // --- reset state ---
      add(1, 4'b0001, 0,0,0,0, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);
      // --- single channel: 1..7 on ch0 ---
      add(0, 4'b0001, 1,0,0,0, 4'b0000, 1, 4'b0001, 0, 0, 0, 0);
      add(0, 4'b0001, 2,0,0,0, 4'b0000, 1, 4'b0001, 1, 0, 1, 1);
      add(0, 4'b0001, 3,0,0,0, 4'b0000, 1, 4'b0001, 1, 0, 3, 1);
      add(0, 4'b0001, 4,0,0,0, 4'b0000, 1, 4'b0001, 1, 0, 6, 1);
      add(0, 4'b0001, 5,0,0,0, 4'b0000, 1, 4'b0001, 1, 0, 10, 1);
      add(0, 4'b0001, 6,0,0,0, 4'b0000, 1, 4'b0001, 1, 0, 15, 1);
      add(0, 4'b0001, 7,0,0,0, 4'b0000, 1, 4'b0001, 1, 0, 20, 1);
      add(0, 4'b0000, 0,0,0,0, 4'b0000, 1, 4'b0000, 1, 0, 25, 1);
      // --- saturation: ch2 sends 31 six times ---
      add(0, 4'b0100, 0,0,31,0, 4'b0000, 1, 4'b0100, 0, 0, 0, 0);
      add(0, 4'b0100, 0,0,31,0, 4'b0000, 1, 4'b0100, 1, 2, 31, 1);
      add(0, 4'b0100, 0,0,31,0, 4'b0000, 1, 4'b0100, 1, 2, 62, 1);
      add(0, 4'b0100, 0,0,31,0, 4'b0000, 1, 4'b0100, 1, 2, 93, 1);
      add(0, 4'b0100, 0,0,31,0, 4'b0000, 1, 4'b0100, 1, 2, 124, 1);
      add(0, 4'b0100, 0,0,31,0, 4'b0000, 1, 4'b0100, 1, 2, 155, 1);
      add(0, 4'b1000, 0,0,0,4,  4'b0000, 1, 4'b1000, 1, 2, 155, 1);
      // --- fairness: all channels valid ---
      add(0, 4'b1111, 1,2,3,4, 4'b0000, 1, 4'b0001, 1, 3, 4, 1);
      add(0, 4'b1111, 1,2,3,4, 4'b0000, 1, 4'b0010, 1, 0, 23, 1);
      add(0, 4'b1111, 1,2,3,4, 4'b0000, 1, 4'b0100, 1, 1, 2, 1);
      add(0, 4'b1111, 1,2,3,4, 4'b0000, 1, 4'b1000, 1, 2, 127, 1);
      add(0, 4'b1111, 1,2,3,4, 4'b0000, 1, 4'b0001, 1, 3, 8, 1);
      add(0, 4'b1111, 1,2,3,4, 4'b0000, 1, 4'b0010, 1, 0, 20, 1);
      // --- backpressure: ch1, ch3 valid, out_ready low 3 cycles ---
      add(0, 4'b1010, 0,2,0,4, 4'b0000, 0, 4'b0000, 1, 1, 4, 1);
      add(0, 4'b1010, 0,2,0,4, 4'b0000, 0, 4'b0000, 1, 1, 4, 1);
      add(0, 4'b1010, 0,2,0,4, 4'b0000, 0, 4'b0000, 1, 1, 4, 1);
      add(0, 4'b1010, 0,2,0,4, 4'b0000, 1, 4'b1000, 1, 1, 4, 1);
      add(0, 4'b1010, 0,2,0,4, 4'b0000, 1, 4'b0010, 1, 3, 12, 1);
      add(0, 4'b0000, 0,0,0,0, 4'b0000, 1, 4'b0000, 1, 1, 6, 1);
      // --- clear collision: build 5,5,5 on ch0, then data 9 with clear ---
      add(0, 4'b0000, 0,0,0,0, 4'b0001, 1, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b0001, 5,0,0,0, 4'b0000, 1, 4'b0001, 0, 0, 0, 0);
      add(0, 4'b0001, 5,0,0,0, 4'b0000, 1, 4'b0001, 1, 0, 5, 1);
      add(0, 4'b0001, 5,0,0,0, 4'b0000, 1, 4'b0001, 1, 0, 10, 1);
      add(0, 4'b0001, 9,0,0,0, 4'b0001, 1, 4'b0000, 1, 0, 15, 1);
      add(0, 4'b0001, 9,0,0,0, 4'b0100, 1, 4'b0001, 0, 0, 0, 0);
      // --- reset mid-stream while out_valid=1 ---
      add(1, 4'b0010, 0,2,0,0, 4'b0000, 1, 4'b0000, 1, 0, 9, 1);
      add(0, 4'b0001, 4,0,0,0, 4'b0000, 1, 4'b0001, 0, 0, 0, 1);
      add(0, 4'b0000, 0,0,0,0, 4'b0000, 1, 4'b0000, 1, 0, 4, 1);
      add(0, 4'b0010, 0,2,0,0, 4'b0000, 1, 4'b0010, 0, 0, 0, 0);
      add(0, 4'b0000, 0,0,0,0, 4'b0000, 1, 4'b0000, 1, 1, 2, 1);

      // Initial reset edge
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.chan_clr  = '0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         reset         = vecs[i].rst;
         bus.req_valid = vecs[i].valid;
         bus.req_data  = vecs[i].data;
         bus.chan_clr  = vecs[i].clr;
         bus.out_ready = vecs[i].ordy;
         #3;
         check($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_ready));
         check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
         if (vecs[i].chk) begin
            check($sformatf("v%0d out_chan", i), 32'(bus.out_chan), 32'(vecs[i].e_chan));
            check($sformatf("v%0d out_sum", i),  32'(bus.out_sum),  32'(vecs[i].e_sum));
         end
         @(posedge clk);
         #1;
      end

      // --- hand sequence: latency and hold under backpressure on ch2 ---
      reset         = 1'b0;
      bus.req_valid = 4'b0100;
      bus.req_data  = {5'd0, 5'd7, 5'd0, 5'd0};
      bus.chan_clr  = '0;
      bus.out_ready = 1'b0;
      #3;
      check("seq first grant", 32'(bus.req_ready), 32'b0100);
      @(posedge clk);
      #1;
      waited = 0;
      while (!bus.out_valid && waited < 5) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("seq latency", 32'(waited), 32'd0);
      check("seq chan", 32'(bus.out_chan), 32'd2);
      check("seq sum", 32'(bus.out_sum), 32'd7);
      for (int c = 0; c < 2; c++) begin
         #3;
         check($sformatf("seq stall%0d ready", c), 32'(bus.req_ready), 32'd0);
         check($sformatf("seq stall%0d valid", c), 32'(bus.out_valid), 32'd1);
         check($sformatf("seq stall%0d sum", c),   32'(bus.out_sum),   32'd7);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      #3;
      check("seq release ready", 32'(bus.req_ready), 32'b0100);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      check("seq second sum", 32'(bus.out_sum), 32'd14);
      check("seq second chan", 32'(bus.out_chan), 32'd2);
      @(posedge clk);
      #1;
      check("seq drain valid", 32'(bus.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
